// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing, frame width and the rx/tx state encoding.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 56 * 16;
  localparam int unsigned DATA_BITS         = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
module sync2 #(
  parameter logic rst_val = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= rst_val;
      q    <= rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: start-edge detect, mid-bit sampling, one-cycle valid/frame_err pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clks_per_bit = UART_CLKS_PER_BIT,
  parameter int unsigned half_bit     = clks_per_bit >> 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(clks_per_bit) + 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(half_bit - 1);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(clks_per_bit - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 prev;
  uart_state_e          state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BIT_W-1:0]     bit_idx, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [7:0]           data_n;
  logic                 valid_n, frame_err_n, busy_n;

  sync2 #(.rst_val(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      prev      <= 1'b1;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shift     <= shift_n;
      prev      <= rx_s;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + CNT_W'(1);
    bit_n       = bit_idx;
    shift_n     = shift;
    data_n      = data;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    busy_n      = busy;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (prev && !rx_s) begin
          state_n = START;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (cnt == H_LAST) begin
          cnt_n = '0;
          bit_n = '0;
          if (rx_s) begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (cnt == C_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          if (bit_idx == BIT_LAST) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (cnt == C_LAST) begin
          cnt_n  = '0;
          busy_n = 1'b0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low (break) line must return high before a new start can be seen.
        cnt_n = '0;
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
